// File: rtl/minterm_pkg.sv
// Shared types and constants for the programmable sum-of-minterms function unit.
package minterm_pkg;

  localparam int TT_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  function automatic bit n_in_legal(input int n);
    return (n >= 2) && (n <= 6);
  endfunction

endpackage

// File: rtl/minterm_lut.sv
// Combinational truth-table select: f = tt[sel]. Shared by the lookup and sweep paths.
module minterm_lut
  import minterm_pkg::*;
#(
  parameter int N_IN = 4,
  localparam int TT_W = 2**N_IN
) (
  input  logic [TT_W-1:0] tt,
  input  logic [N_IN-1:0] sel,
  output logic            f
);

  assign f = tt[sel];

endmodule

// File: rtl/minterm_sweep_eval.sv
// N-input sum-of-minterms unit: streamed lookups, or an exhaustive self-generated sweep
// of all 2^N_IN input vectors with a count of the minterms seen.
module minterm_sweep_eval
  import minterm_pkg::*;
#(
  parameter int          N_IN    = 4,
  parameter logic [63:0] TT_INIT = 64'hDF03,
  localparam int         TT_W    = 2**N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [TT_W-1:0] cfg_tt,
  output logic            cfg_err,
  input  logic            sweep_start,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic [N_IN:0]   minterm_cnt,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_vec,
  output logic            in_ready,
  output logic            out_valid,
  output logic [N_IN-1:0] out_vec,
  output logic            out_f,
  input  logic            out_ready
);

  if (!n_in_legal(N_IN) || (TT_W > TT_MAX_W)) begin : g_param_check
    $error("minterm_sweep_eval: N_IN must be in 2..6");
  end

  localparam logic [N_IN:0] IDX_END = (N_IN+1)'(TT_W);

  state_t          state, state_nx;
  logic [TT_W-1:0] tt_q;
  logic [N_IN:0]   idx;
  logic            out_sweep;
  logic [N_IN-1:0] lut_sel;
  logic            lut_f;
  logic            can_load, sweep_issue, lookup_acc, beat_acc, sweep_acc;

  assign can_load    = !out_valid || out_ready;
  assign in_ready    = (state == IDLE) && !sweep_start && can_load;
  assign sweep_issue = (state == SWEEP) && can_load && (idx != IDX_END);
  assign lookup_acc  = in_valid && in_ready;
  assign beat_acc    = out_valid && out_ready;
  // A lookup result still pending when the sweep starts must not be counted.
  assign sweep_acc   = (state == SWEEP) && beat_acc && out_sweep;
  assign sweep_busy  = (state != IDLE);
  assign sweep_done  = (state == DONE);
  assign lut_sel     = (state == SWEEP) ? idx[N_IN-1:0] : in_vec;

  minterm_lut #(.N_IN(N_IN)) u_lut (
    .tt  (tt_q),
    .sel (lut_sel),
    .f   (lut_f)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (sweep_start) state_nx = SWEEP;
      SWEEP:   if ((idx == IDX_END) && sweep_acc) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q        <= TT_INIT[TT_W-1:0];
      idx         <= '0;
      minterm_cnt <= '0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= cfg_we && (state != IDLE);
      if (cfg_we && (state == IDLE)) tt_q <= cfg_tt;
      if ((state == IDLE) && sweep_start) begin
        idx         <= '0;
        minterm_cnt <= '0;
      end else begin
        if (sweep_issue) idx <= idx + (N_IN+1)'(1);
        if (sweep_acc)   minterm_cnt <= minterm_cnt + (N_IN+1)'(out_f);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_f     <= 1'b0;
      out_sweep <= 1'b0;
    end else if (sweep_issue) begin
      out_valid <= 1'b1;
      out_vec   <= idx[N_IN-1:0];
      out_f     <= lut_f;
      out_sweep <= 1'b1;
    end else if (lookup_acc) begin
      out_valid <= 1'b1;
      out_vec   <= in_vec;
      out_f     <= lut_f;
      out_sweep <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_minterm_sweep_eval.sv
// Self-checking bench: N_IN=4 and N_IN=2 instances against a truth-table reference model.
module tb_minterm_sweep_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        cfg_we, cfg_err, sweep_start, sweep_busy, sweep_done;
  logic [15:0] cfg_tt;
  logic [4:0]  minterm_cnt;
  logic        in_valid, in_ready, out_valid, out_f, out_ready;
  logic [3:0]  in_vec, out_vec;

  logic        cfg_we_b, cfg_err_b, sweep_start_b, sweep_busy_b, sweep_done_b;
  logic [3:0]  cfg_tt_b;
  logic [2:0]  minterm_cnt_b;
  logic        in_valid_b, in_ready_b, out_valid_b, out_f_b, out_ready_b;
  logic [1:0]  in_vec_b, out_vec_b;

  minterm_sweep_eval #(.N_IN(4), .TT_INIT(64'hDF03)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_tt(cfg_tt), .cfg_err(cfg_err),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .minterm_cnt(minterm_cnt), .in_valid(in_valid), .in_vec(in_vec), .in_ready(in_ready),
    .out_valid(out_valid), .out_vec(out_vec), .out_f(out_f), .out_ready(out_ready)
  );

  minterm_sweep_eval #(.N_IN(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we_b), .cfg_tt(cfg_tt_b), .cfg_err(cfg_err_b),
    .sweep_start(sweep_start_b), .sweep_busy(sweep_busy_b), .sweep_done(sweep_done_b),
    .minterm_cnt(minterm_cnt_b), .in_valid(in_valid_b), .in_vec(in_vec_b), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_vec(out_vec_b), .out_f(out_f_b), .out_ready(out_ready_b)
  );

  int errors = 0;
  int checks = 0;
  logic [15:0] model_tt = 16'hDF03;
  logic [3:0]  got_vec[$];
  logic        got_f[$];
  int done_gap, stall_bad, cfg_err_hits, cfg_err_first;

  // Starts a sweep on the 4-input unit and records every accepted beat.
  // mode: 0 ready always, 1 ready 1010.., 2 random ready. stop_beats>0 aborts early.
  task automatic run_sweep(input int mode, input int cfg_cycle, input int stop_beats,
                           input bit load_tt, input logic [15:0] new_tt);
    bit pstall = 1'b0;
    logic [3:0] pv = '0;
    logic pf = 1'b0;
    int last_acc = -100;
    @(negedge clk);
    sweep_start = 1'b1; cfg_we = load_tt; cfg_tt = new_tt;
    @(negedge clk);
    sweep_start = 1'b0; cfg_we = 1'b0;
    got_vec.delete(); got_f.delete();
    done_gap = -1; stall_bad = 0; cfg_err_hits = 0; cfg_err_first = -1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (pstall && (out_valid !== 1'b1 || out_vec !== pv || out_f !== pf)) stall_bad++;
      if (cfg_err === 1'b1) begin
        cfg_err_hits++;
        if (cfg_err_first < 0) cfg_err_first = cyc;
      end
      if (sweep_done === 1'b1) begin
        done_gap = cyc - last_acc;
        break;
      end
      if (stop_beats > 0 && got_vec.size() >= stop_beats) break;
      cfg_we = (cyc == cfg_cycle);
      cfg_tt = '0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom);
      endcase
      #1;
      pstall = out_valid && !out_ready; pv = out_vec; pf = out_f;
      if (out_valid && out_ready) begin
        got_vec.push_back(out_vec);
        got_f.push_back(out_f);
        last_acc = cyc;
      end
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cfg_we = 0; cfg_tt = '0; sweep_start = 0; in_valid = 0; in_vec = '0; out_ready = 0;
    cfg_we_b = 0; cfg_tt_b = '0; sweep_start_b = 0; in_valid_b = 0; in_vec_b = '0; out_ready_b = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || sweep_busy !== 1'b0 || minterm_cnt !== 5'd0 ||
        sweep_done !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b busy=%b cnt=%0d done=%b cfg_err=%b, required all 0",
               out_valid, sweep_busy, minterm_cnt, sweep_done, cfg_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    in_valid = 1'b1; in_vec = 4'b1010; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_vec !== 4'b1010 || out_f !== model_tt[10]) begin
      errors++;
      $display("FAIL lookup_1010: valid=%b vec=%b f=%b, required 1 1010 %b", out_valid, out_vec, out_f, model_tt[10]);
    end
    in_vec = 4'b0010;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_vec !== 4'b0010 || out_f !== model_tt[2]) begin
      errors++;
      $display("FAIL lookup_0010: valid=%b vec=%b f=%b, required 1 0010 %b", out_valid, out_vec, out_f, model_tt[2]);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL lookup_drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_sweep(input string tag, input int mode, input int cfg_cycle,
                            input bit load_tt, input logic [15:0] new_tt);
    if (load_tt) model_tt = new_tt;
    run_sweep(mode, cfg_cycle, 0, load_tt, new_tt);
    checks++;
    if (got_vec.size() != 16) begin
      errors++; $display("FAIL %s_beats: got %0d beats, required 16", tag, got_vec.size());
    end
    for (int i = 0; i < got_vec.size(); i++) begin
      checks++;
      if (got_vec[i] !== i[3:0] || got_f[i] !== model_tt[i]) begin
        errors++;
        $display("FAIL %s_beat%0d: vec=%0d f=%b, required vec=%0d f=%b", tag, i, got_vec[i], got_f[i], i, model_tt[i]);
      end
    end
    checks++;
    if (stall_bad != 0) begin
      errors++; $display("FAIL %s_stall: %0d unstable stalled cycles, required 0", tag, stall_bad);
    end
    checks++;
    if (done_gap != 1 || sweep_busy !== 1'b1) begin
      errors++; $display("FAIL %s_done: gap=%0d busy=%b, required gap=1 busy=1", tag, done_gap, sweep_busy);
    end
    checks++;
    if (minterm_cnt !== 5'($countones(model_tt))) begin
      errors++; $display("FAIL %s_cnt: got %0d, required %0d", tag, minterm_cnt, $countones(model_tt));
    end
    if (cfg_cycle >= 0) begin
      checks++;
      if (cfg_err_hits != 1 || cfg_err_first != cfg_cycle + 1) begin
        errors++;
        $display("FAIL %s_cfg_err: hits=%0d first=%0d, required hits=1 first=%0d", tag, cfg_err_hits, cfg_err_first, cfg_cycle + 1);
      end
    end
    @(negedge clk);
    checks++;
    if (sweep_done !== 1'b0 || sweep_busy !== 1'b0) begin
      errors++; $display("FAIL %s_idle: done=%b busy=%b, required 0 0", tag, sweep_done, sweep_busy);
    end
  endtask

  task automatic test_lookup_random;
    logic [3:0] exp_vec[$];
    logic       exp_f[$];
    logic [3:0] pv = '0;
    logic       pf = 1'b0;
    bit         pstall = 1'b0;
    logic [3:0] ev;
    logic       ef;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (pstall) begin
        checks++;
        if (out_valid !== 1'b1 || out_vec !== pv || out_f !== pf) begin
          errors++; $display("FAIL rnd_stall: vec=%0d f=%b, required held vec=%0d f=%b", out_vec, out_f, pv, pf);
        end
      end
      in_valid  = 1'($urandom);
      in_vec    = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 15) == 0);
      cfg_tt    = 16'($urandom);
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++; $display("FAIL rnd_in_ready: got %b, required %b", in_ready, !out_valid || out_ready);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_vec.size() == 0) begin
          errors++; $display("FAIL rnd_extra_beat: vec=%0d f=%b, required no beat", out_vec, out_f);
        end else begin
          ev = exp_vec.pop_front(); ef = exp_f.pop_front();
          if (out_vec !== ev || out_f !== ef) begin
            errors++; $display("FAIL rnd_beat: vec=%0d f=%b, required vec=%0d f=%b", out_vec, out_f, ev, ef);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_vec.push_back(in_vec);
        exp_f.push_back(model_tt[in_vec]);
      end
      if (cfg_we) model_tt = cfg_tt;
      pstall = out_valid && !out_ready; pv = out_vec; pf = out_f;
      @(negedge clk);
    end
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    #1;
    if (out_valid && exp_vec.size() != 0) begin
      ev = exp_vec.pop_front(); ef = exp_f.pop_front();
      checks++;
      if (out_vec !== ev || out_f !== ef) begin
        errors++; $display("FAIL rnd_last_beat: vec=%0d f=%b, required vec=%0d f=%b", out_vec, out_f, ev, ef);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || exp_vec.size() != 0) begin
      errors++; $display("FAIL rnd_drain: out_valid=%b pending=%0d, required 0 0", out_valid, exp_vec.size());
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] t = 16'($urandom);
    if (t == 16'hDF03) t = 16'h1234;
    model_tt = t;
    run_sweep(0, -1, 8, 1'b1, t);
    checks++;
    if (got_vec.size() != 8 || got_vec[7] !== 4'd7) begin
      errors++; $display("FAIL mid_pre_reset: beats=%0d, required 8 ending at 7", got_vec.size());
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_vec !== 4'd0 || out_f !== 1'b0 || sweep_busy !== 1'b0 ||
        minterm_cnt !== 5'd0 || sweep_done !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: valid=%b vec=%0d f=%b busy=%b cnt=%0d done=%b, required all 0",
               out_valid, out_vec, out_f, sweep_busy, minterm_cnt, sweep_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_tt = 16'hDF03;
    test_sweep("post_reset", 0, -1, 1'b0, '0);
  endtask

  task automatic test_n2;
    logic [3:0] model_b = 4'b0110;
    logic [1:0] vb[$];
    logic       fb[$];
    int ir_bad = 0;
    bit done_seen = 1'b0;
    @(negedge clk);
    cfg_we_b = 1'b1; cfg_tt_b = model_b; out_ready_b = 1'b1;
    @(negedge clk);
    cfg_we_b = 1'b0; sweep_start_b = 1'b1; in_valid_b = 1'b1; in_vec_b = 2'd3;
    #1;
    if (in_ready_b !== 1'b0) ir_bad++;
    @(negedge clk);
    sweep_start_b = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (in_ready_b !== 1'b0) ir_bad++;
      if (sweep_done_b === 1'b1) begin
        done_seen = 1'b1;
        break;
      end
      #1;
      if (out_valid_b && out_ready_b) begin
        vb.push_back(out_vec_b);
        fb.push_back(out_f_b);
      end
      @(negedge clk);
    end
    in_valid_b = 1'b0;
    checks++;
    if (!done_seen || vb.size() != 4) begin
      errors++; $display("FAIL n2_beats: done=%b beats=%0d, required 1 4", done_seen, vb.size());
    end
    for (int i = 0; i < vb.size(); i++) begin
      checks++;
      if (vb[i] !== i[1:0] || fb[i] !== model_b[i]) begin
        errors++; $display("FAIL n2_beat%0d: vec=%0d f=%b, required vec=%0d f=%b", i, vb[i], fb[i], i, model_b[i]);
      end
    end
    checks++;
    if (minterm_cnt_b !== 3'($countones(model_b))) begin
      errors++; $display("FAIL n2_cnt: got %0d, required %0d", minterm_cnt_b, $countones(model_b));
    end
    checks++;
    if (ir_bad != 0) begin
      errors++; $display("FAIL n2_in_ready: high on %0d cycles, required 0", ir_bad);
    end
  endtask

  initial begin
    test_reset;
    test_sweep("sweep", 0, -1, 1'b0, '0);
    test_sweep("toggle", 1, -1, 1'b0, '0);
    test_sweep("cfg_busy", 0, 5, 1'b0, '0);
    test_sweep("cfg_and_start", 0, -1, 1'b1, 16'h0001);
    test_lookup_random;
    test_sweep("rnd_sweep", 2, -1, 1'b1, 16'($urandom));
    test_reset_mid;
    test_n2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
